// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Chunked ripple-carry adder. The operands are split into STAGES
//            chunks of CW = WIDTH/STAGES bits. One chunk is added per stage,
//            least significant chunk first, and the carry is registered
//            between stages. The whole pipeline advances as one unit and
//            stalls under output backpressure.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - operand beat valid
//            in_ready  - beat accepted this cycle when in_valid is also high
//            a, b      - WIDTH-bit operands
//            cin       - carry in
//            out_valid - result beat valid
//            out_ready - downstream accepts the result
//            sum       - a+b+cin modulo 2^WIDTH
//            cout      - carry out of bit WIDTH-1
//            ovf       - signed overflow flag
// Options  : define PIPELINED_ADDER_OVF_EN to compute ovf. Without it ovf
//            is tied to 0 and no overflow register is built.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  // Ones in the low CW bits; shifted up to select the chunk owned by a stage.
  localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CW);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  // Each stage keeps one word in acc_q: its low (k+1) chunks are finished
  // sum bits, the chunks above are still the untouched a operand. The b
  // operand rides along in opb_q so its upper chunks arrive skewed in step
  // with the carry.
  logic [WIDTH-1:0] acc_q   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;

  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [CW:0]      chunk_sum [STAGES];
  logic [WIDTH-1:0] acc_d     [STAGES];
  logic [STAGES-1:0] carry_d;

  logic advance;

  // The pipeline moves as a whole: any free slot at the output lets every
  // stage shift, so no per-stage ready chain is needed.
  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_a[k] = a;
      assign src_b[k] = b;
      assign src_c[k] = cin;
      assign src_v[k] = in_valid;
    end else begin : g_body
      assign src_a[k] = acc_q[k-1];
      assign src_b[k] = opb_q[k-1];
      assign src_c[k] = carry_q[k-1];
      assign src_v[k] = valid_q[k-1];
    end

    assign chunk_sum[k] = {1'b0, src_a[k][k*CW +: CW]}
                        + {1'b0, src_b[k][k*CW +: CW]}
                        + {{CW{1'b0}}, src_c[k]};

    // Replace chunk k of the travelling word with its freshly computed sum.
    assign acc_d[k]   = (src_a[k] & ~(CHUNK_MASK << (k*CW)))
                      | (WIDTH'(chunk_sum[k][CW-1:0]) << (k*CW));
    assign carry_d[k] = chunk_sum[k][CW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= src_v;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        opb_q[k] <= src_b[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = acc_q[LAST];
  assign cout      = carry_q[LAST];

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // The last stage still sees the original operand sign bits (the top chunk
  // of the travelling word has not been overwritten yet), so overflow is
  // resolved alongside the final chunk and registered with the beat.
  assign ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
              && (acc_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
//            Expected results come from plain integer arithmetic on the
//            operands, queued in acceptance order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t        m;
    logic [16:0] full;
    int          sv;
    full = 17'(x) + 17'(y) + 17'(c);
    m.s  = full[15:0];
    m.c  = full[16];
    sv   = int'($signed(x)) + int'($signed(y)) + int'(c);
    m.o  = OVF_EN ? ((sv > 32767) || (sv < -32768)) : 1'b0;
    return m;
  endfunction

  // One clock: score the handshakes seen this cycle, cross the rising edge,
  // and return at the following falling edge with inputs free to change.
  task automatic tick();
    bit   acc;
    bit   emit;
    exp_t e;
    #1;
    acc  = in_valid && in_ready && !rst;
    emit = out_valid && out_ready && !rst;
    if (emit) begin
      check("sb_expected_beat", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        check("sb_sum",  32'(sum),  32'(e.s));
        check("sb_cout", 32'(cout), 32'(e.c));
        check("sb_ovf",  32'(ovf),  32'(e.o));
      end
    end
    if (acc) q.push_back(model(a, b, cin));
    @(posedge clk);
    if (rst) q.delete();
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic [15:0] es, input logic ec,
                          input logic eo);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      #1;
      check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(sum),       32'(es));
    check({tag, "_cout"},  32'(cout),      32'(ec));
    check({tag, "_ovf"},   32'(ovf),       32'(eo));
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int idx;
    int pop0;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();

    // Reset state, sampled while rst is still asserted.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Wrap, overflow and cross-chunk carry cases with latency STAGES.
    directed("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_EN);
    directed("cin",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    directed("xchunk", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, OVF_EN);

    // Ten back-to-back beats with a three-cycle output stall mid-stream.
    idx  = 0;
    pop0 = n_pop;
    for (int cyc = 0; cyc < 60 && (idx < 10 || q.size() > 0); cyc++) begin
      in_valid  = (idx < 10);
      a         = 16'(idx);
      b         = 16'(16'h0100 * idx);
      cin       = 1'b0;
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (!out_ready) begin
        check("stall_in_ready",  32'(in_ready),  32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_queue",     32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check("stall_sum_hold", 32'(sum), 32'(q[0].s));
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    check("burst_accepted", 32'(idx), 32'd10);
    check("burst_emitted",  32'(n_pop - pop0), 32'd10);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    // Reset with three beats in flight, and a beat offered during reset.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = 1'b1;
      tick();
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h4321;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_sum",       32'(sum),       32'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("post_rst_no_beat", 32'(out_valid), 32'd0);
      tick();
    end
    directed("after_rst", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
